// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: hazard inputs from ID/EX stages,
// stall/flush/hold controls and performance/error status back to the pipeline.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_RegAddrRt_i;
    logic [4:0]       IFID_RegAddrRs_i;
    logic [4:0]       IFID_RegAddrRt_i;
    logic             BranchTaken_i;
    logic             Jump_i;
    logic             MemBusy_i;
    logic             PCWrite_o;
    logic             IFIDWrite_o;
    logic             IFIDFlush_o;
    logic             IDEXBubble_o;
    logic             PipeHold_o;
    logic             MemTimeout_o;
    logic [CNT_W-1:0] StallCnt_o;

    modport master (
        output IDEX_MemRead_i, IDEX_RegAddrRt_i, IFID_RegAddrRs_i, IFID_RegAddrRt_i,
               BranchTaken_i, Jump_i, MemBusy_i,
        input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeHold_o,
               MemTimeout_o, StallCnt_o
    );

    modport slave (
        input  IDEX_MemRead_i, IDEX_RegAddrRt_i, IFID_RegAddrRs_i, IFID_RegAddrRt_i,
               BranchTaken_i, Jump_i, MemBusy_i,
        output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeHold_o,
               MemTimeout_o, StallCnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch
// flushes, data-memory wait sequencing with timeout, and a stall-cycle counter.
module hazard_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave hz
);
    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t           r_state, w_next;
    logic [WCW-1:0]   r_wait_cnt, w_wait_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout;

    logic w_lu, w_redirect;
    logic w_pcw, w_ifidw, w_flush, w_bubble, w_hold;

    assign w_lu = hz.IDEX_MemRead_i && (hz.IDEX_RegAddrRt_i != 5'd0) &&
                  ((hz.IDEX_RegAddrRt_i == hz.IFID_RegAddrRs_i) ||
                   (hz.IDEX_RegAddrRt_i == hz.IFID_RegAddrRt_i));
    assign w_redirect = hz.BranchTaken_i | hz.Jump_i;

    always_comb begin
        w_pcw      = 1'b0;
        w_ifidw    = 1'b0;
        w_flush    = 1'b0;
        w_bubble   = 1'b0;
        w_hold     = 1'b0;
        w_next     = r_state;
        w_wait_nxt = r_wait_cnt;
        if (rst_i) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
        end else begin
            case (r_state)
                RUN, MEM_WAIT: begin
                    if (hz.MemBusy_i) begin
                        w_hold = 1'b1;
                        if (r_state == RUN) begin
                            w_next     = MEM_WAIT;
                            w_wait_nxt = WCW'(1);
                        end else if (r_wait_cnt == WCW'(MAX_WAIT)) begin
                            w_next = ERR;
                        end else begin
                            w_wait_nxt = r_wait_cnt + WCW'(1);
                        end
                    end else begin
                        // Same-cycle release: a pending branch loses to load-use
                        // and is seen again once the bubble has gone through.
                        w_pcw      = ~w_lu;
                        w_ifidw    = ~w_lu;
                        w_bubble   = w_lu;
                        w_flush    = ~w_lu & w_redirect;
                        w_next     = RUN;
                        w_wait_nxt = '0;
                    end
                end
                ERR: w_hold = 1'b1;
                default: begin
                    w_next     = RUN;
                    w_wait_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (!w_pcw && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_next == ERR)
                r_timeout <= 1'b1;
        end
    end

    assign hz.PCWrite_o    = w_pcw;
    assign hz.IFIDWrite_o  = w_ifidw;
    assign hz.IFIDFlush_o  = w_flush;
    assign hz.IDEXBubble_o = w_bubble;
    assign hz.PipeHold_o   = w_hold;
    assign hz.MemTimeout_o = r_timeout;
    assign hz.StallCnt_o   = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural model.
module tb_hazard_ctrl;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz();
    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (hz)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit chk_en   = 1'b0;

    // Model state: consecutive busy cycles seen, error latch, stall count.
    int m_busy_run = 0;
    bit m_err      = 1'b0;
    int m_stall    = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeHold}
    function automatic logic [4:0] model_ctl();
        bit lu;
        lu = hz.IDEX_MemRead_i && hz.IDEX_RegAddrRt_i != 0 &&
             (hz.IDEX_RegAddrRt_i == hz.IFID_RegAddrRs_i ||
              hz.IDEX_RegAddrRt_i == hz.IFID_RegAddrRt_i);
        if (rst_i)                      return 5'b00110;
        if (m_err || hz.MemBusy_i)      return 5'b00001;
        if (lu)                         return 5'b00010;
        if (hz.BranchTaken_i || hz.Jump_i) return 5'b11100;
        return 5'b11000;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_busy_run <= 0;
            m_err      <= 1'b0;
            m_stall    <= 0;
        end else begin
            if (!model_ctl()[4] && m_stall < SAT) m_stall <= m_stall + 1;
            if (!m_err) begin
                if (hz.MemBusy_i) begin
                    m_busy_run <= m_busy_run + 1;
                    if (m_busy_run + 1 == MAX_WAIT + 1) m_err <= 1'b1;
                end else begin
                    m_busy_run <= 0;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("ctl", 16'({hz.PCWrite_o, hz.IFIDWrite_o, hz.IFIDFlush_o,
                              hz.IDEXBubble_o, hz.PipeHold_o}), 16'(model_ctl()));
            check("timeout", 16'(hz.MemTimeout_o), 16'(m_err));
            check("stallcnt", 16'(hz.StallCnt_o), 16'(m_stall));
        end
    end

    task automatic drive(input bit mr, input int ert, input int rs, input int rt,
                         input bit br, input bit j, input bit busy);
        hz.IDEX_MemRead_i   = mr;
        hz.IDEX_RegAddrRt_i = 5'(ert);
        hz.IFID_RegAddrRs_i = 5'(rs);
        hz.IFID_RegAddrRt_i = 5'(rt);
        hz.BranchTaken_i    = br;
        hz.Jump_i           = j;
        hz.MemBusy_i        = busy;
    endtask

    // Drive just after the edge, leaving time for a literal check before negedge.
    task automatic cyc(input bit mr, input int ert, input int rs, input int rt,
                       input bit br, input bit j, input bit busy);
        @(posedge clk_i);
        #1 drive(mr, ert, rs, rt, br, j, busy);
        #1;
    endtask

    initial begin
        int busy_left;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_i = 1'b1;
        #1;
        check("rst_pcw", 16'(hz.PCWrite_o), 16'd0);
        check("rst_flush_bubble", 16'({hz.IFIDFlush_o, hz.IDEXBubble_o}), 16'b11);
        chk_en = 1'b1;
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        check("idle_pcw_ifidw", 16'({hz.PCWrite_o, hz.IFIDWrite_o}), 16'b11);
        check("idle_stallcnt", 16'(hz.StallCnt_o), 16'd0);

        // Load-use on Rs: one stall cycle.
        cyc(1, 5, 5, 1, 0, 0, 0);
        check("lu_ctl", 16'({hz.PCWrite_o, hz.IFIDWrite_o, hz.IDEXBubble_o}), 16'b001);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("lu_stall1", 16'(hz.StallCnt_o), 16'd1);
        check("lu_release", 16'(hz.PCWrite_o), 16'd1);
        // Load into r0 never stalls.
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("lu_r0", 16'(hz.PCWrite_o), 16'd1);

        // Load-use beats a taken branch, branch flushes next cycle.
        cyc(1, 5, 5, 0, 1, 0, 0);
        check("lu_br_flush", 16'({hz.IFIDFlush_o, hz.IDEXBubble_o}), 16'b01);
        cyc(0, 5, 5, 0, 1, 0, 0);
        check("br_flush", 16'({hz.IFIDFlush_o, hz.PCWrite_o}), 16'b11);
        check("br_stall2", 16'(hz.StallCnt_o), 16'd2);

        // MAX_WAIT busy cycles: held, then released without error.
        for (int i = 0; i < MAX_WAIT; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            check("wait_hold", 16'(hz.PipeHold_o), 16'd1);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("wait_release", 16'({hz.PipeHold_o, hz.PCWrite_o, hz.MemTimeout_o}), 16'b010);
        check("wait_stall6", 16'(hz.StallCnt_o), 16'd6);

        // MAX_WAIT+1 busy cycles: timeout, sticky hold; counter saturates.
        for (int i = 0; i < MAX_WAIT + 1; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("err_timeout", 16'({hz.MemTimeout_o, hz.PipeHold_o, hz.PCWrite_o}), 16'b110);
        check("err_stall11", 16'(hz.StallCnt_o), 16'd11);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        check("sat_stall", 16'(hz.StallCnt_o), 16'(SAT));
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("sat_hold", 16'({hz.StallCnt_o, hz.MemTimeout_o}), 16'({4'(SAT), 1'b1}));

        // Async reset mid-cycle clears everything immediately.
        #1 rst_i = 1'b1;
        #1;
        check("arst_ctl", 16'({hz.PCWrite_o, hz.IFIDFlush_o, hz.IDEXBubble_o, hz.PipeHold_o}), 16'b0110);
        check("arst_state", 16'({hz.StallCnt_o, hz.MemTimeout_o}), 16'd0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;

        // Random traffic with busy bursts long enough to cross the timeout.
        busy_left = 0;
        for (int n = 0; n < 3000; n++) begin
            bit busy;
            if (busy_left == 0 && $urandom_range(0, 5) == 0) busy_left = $urandom_range(1, 7);
            busy = (busy_left != 0);
            if (busy_left != 0) busy_left--;
            @(posedge clk_i);
            #1 drive($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 4) == 0,
                     $urandom_range(0, 7) == 0, busy);
            if ((m_err && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0) begin
                #2 rst_i = 1'b1;
                #5 rst_i = 1'b0;
                busy_left = 0;
            end
        end
        @(posedge clk_i);
        #1 chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
